// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding.
// Holds the decoded instruction for EX, inserts bubbles on load-use stalls
// and branch flushes, freezes on memory stalls, and muxes forwarded values
// into the ALU operands and store data.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold_pipe,
  input  logic              flush_ID,
  input  logic              Stall_ID,
  input  logic [1:0]        OP_A_SEL,
  input  logic [1:0]        OP_B_SEL,
  input  logic [DATA_W-1:0] Rs_val_ID,
  input  logic [DATA_W-1:0] Rt_val_ID,
  input  logic [DATA_W-1:0] imm_ID,
  input  logic [REG_W-1:0]  Rw_ID,
  input  logic              ALU_SRC_ID,
  input  logic [3:0]        alu_ctrl_ID,
  input  logic              we_ID,
  input  logic              LD_ID,
  input  logic              mem_we_ID,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic [REG_W-1:0]  Rw_ID_EX,
  output logic              we_ID_EX,
  output logic              LD_ID_EX,
  output logic              mem_we_EX,
  output logic [3:0]        alu_ctrl_EX,
  output logic [DATA_W-1:0] op_a_EX,
  output logic [DATA_W-1:0] op_b_EX,
  output logic [DATA_W-1:0] store_data_EX,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Registered EX-stage state
  logic [DATA_W-1:0] rs_val_reg, rt_val_reg, imm_reg;
  logic [REG_W-1:0]  rw_reg;
  logic              alu_src_reg;
  logic [3:0]        alu_ctrl_reg;
  logic              we_reg, ld_reg, mem_we_reg;
  logic [1:0]        sel_a_reg, sel_b_reg;
  logic              flush_pend_reg;
  logic [CNT_W-1:0]  bubble_cnt_reg;

  // Edge action, decoded once so both register blocks agree on priority
  logic do_flush, do_stall, do_load, cnt_sat;
  assign do_flush = !hold_pipe && (flush_ID || flush_pend_reg);
  assign do_stall = !hold_pipe && !do_flush && Stall_ID;
  assign do_load  = !hold_pipe && !do_flush && !Stall_ID;
  assign cnt_sat  = (bubble_cnt_reg == {CNT_W{1'b1}});

  // Pipeline register: hold keeps, flush/stall load a bubble, otherwise capture ID
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_val_reg   <= '0;
      rt_val_reg   <= '0;
      imm_reg      <= '0;
      rw_reg       <= '0;
      alu_src_reg  <= 1'b0;
      alu_ctrl_reg <= '0;
      we_reg       <= 1'b0;
      ld_reg       <= 1'b0;
      mem_we_reg   <= 1'b0;
      sel_a_reg    <= '0;
      sel_b_reg    <= '0;
    end else if (do_flush || do_stall) begin
      rs_val_reg   <= '0;
      rt_val_reg   <= '0;
      imm_reg      <= '0;
      rw_reg       <= '0;
      alu_src_reg  <= 1'b0;
      alu_ctrl_reg <= '0;
      we_reg       <= 1'b0;
      ld_reg       <= 1'b0;
      mem_we_reg   <= 1'b0;
      sel_a_reg    <= '0;
      sel_b_reg    <= '0;
    end else if (do_load) begin
      rs_val_reg   <= Rs_val_ID;
      rt_val_reg   <= Rt_val_ID;
      imm_reg      <= imm_ID;
      rw_reg       <= Rw_ID;
      alu_src_reg  <= ALU_SRC_ID;
      alu_ctrl_reg <= alu_ctrl_ID;
      we_reg       <= we_ID;
      ld_reg       <= LD_ID;
      mem_we_reg   <= mem_we_ID;
      sel_a_reg    <= OP_A_SEL;
      sel_b_reg    <= OP_B_SEL;
    end
  end

  // Remember a flush that arrived during hold; count stall bubbles with saturation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_pend_reg <= 1'b0;
      bubble_cnt_reg <= '0;
    end else if (hold_pipe) begin
      if (flush_ID) flush_pend_reg <= 1'b1;
    end else if (do_flush) begin
      flush_pend_reg <= 1'b0;
    end else if (do_stall && !cnt_sat) begin
      bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
    end
  end

  // Forwarding muxes for Rs (index 0) and Rt (index 1); code 11 means no forward
  logic [1:0]        sel_arr [2];
  logic [DATA_W-1:0] src_arr [2];
  logic [DATA_W-1:0] fwd_arr [2];
  assign sel_arr[0] = sel_a_reg;
  assign sel_arr[1] = sel_b_reg;
  assign src_arr[0] = rs_val_reg;
  assign src_arr[1] = rt_val_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_arr[gi] = (sel_arr[gi] == 2'b01) ? ex_mem_result :
                         (sel_arr[gi] == 2'b10) ? mem_wb_data   :
                                                  src_arr[gi];
  end

  assign op_a_EX       = fwd_arr[0];
  assign op_b_EX       = alu_src_reg ? imm_reg : fwd_arr[1];
  assign store_data_EX = fwd_arr[1];

  assign Rw_ID_EX    = rw_reg;
  assign we_ID_EX    = we_reg;
  assign LD_ID_EX    = ld_reg;
  assign mem_we_EX   = mem_we_reg;
  assign alu_ctrl_EX = alu_ctrl_reg;
  assign bubble_cnt  = bubble_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic
// checked against a rule-level model of the EX stage contents.
module tb_id_ex_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              hold_pipe = 1'b0, flush_ID = 1'b0, Stall_ID = 1'b0;
  logic [1:0]        OP_A_SEL = '0, OP_B_SEL = '0;
  logic [DATA_W-1:0] Rs_val_ID = '0, Rt_val_ID = '0, imm_ID = '0;
  logic [REG_W-1:0]  Rw_ID = '0;
  logic              ALU_SRC_ID = 1'b0;
  logic [3:0]        alu_ctrl_ID = '0;
  logic              we_ID = 1'b0, LD_ID = 1'b0, mem_we_ID = 1'b0;
  logic [DATA_W-1:0] ex_mem_result = '0, mem_wb_data = '0;
  logic [REG_W-1:0]  Rw_ID_EX;
  logic              we_ID_EX, LD_ID_EX, mem_we_EX;
  logic [3:0]        alu_ctrl_EX;
  logic [DATA_W-1:0] op_a_EX, op_b_EX, store_data_EX;
  logic [CNT_W-1:0]  bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .hold_pipe(hold_pipe), .flush_ID(flush_ID),
    .Stall_ID(Stall_ID), .OP_A_SEL(OP_A_SEL), .OP_B_SEL(OP_B_SEL),
    .Rs_val_ID(Rs_val_ID), .Rt_val_ID(Rt_val_ID), .imm_ID(imm_ID),
    .Rw_ID(Rw_ID), .ALU_SRC_ID(ALU_SRC_ID), .alu_ctrl_ID(alu_ctrl_ID),
    .we_ID(we_ID), .LD_ID(LD_ID), .mem_we_ID(mem_we_ID),
    .ex_mem_result(ex_mem_result), .mem_wb_data(mem_wb_data),
    .Rw_ID_EX(Rw_ID_EX), .we_ID_EX(we_ID_EX), .LD_ID_EX(LD_ID_EX),
    .mem_we_EX(mem_we_EX), .alu_ctrl_EX(alu_ctrl_EX), .op_a_EX(op_a_EX),
    .op_b_EX(op_b_EX), .store_data_EX(store_data_EX), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the instruction sitting in EX, as a record of its fields
  typedef struct {
    logic [DATA_W-1:0] rs, rt, imm;
    logic [REG_W-1:0]  rw;
    logic              src, we, ld, mwe;
    logic [3:0]        alu;
    logic [1:0]        sa, sb;
  } instr_t;

  instr_t m_ex;
  bit     m_pend;
  int     m_cnt;

  function automatic instr_t bubble_instr();
    instr_t b;
    b.rs = '0; b.rt = '0; b.imm = '0; b.rw = '0; b.src = 1'b0;
    b.we = 1'b0; b.ld = 1'b0; b.mwe = 1'b0; b.alu = '0; b.sa = '0; b.sb = '0;
    return b;
  endfunction

  function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel, input logic [DATA_W-1:0] own);
    if (sel == 2'd1) return ex_mem_result;
    if (sel == 2'd2) return mem_wb_data;
    return own;
  endfunction

  task automatic model_reset();
    m_ex = bubble_instr(); m_pend = 0; m_cnt = 0;
  endtask

  // Apply the per-edge rules to the model using the inputs present at the edge
  task automatic model_edge();
    if (reset) model_reset();
    else if (hold_pipe) begin
      if (flush_ID) m_pend = 1;
    end else if (flush_ID || m_pend) begin
      m_ex = bubble_instr(); m_pend = 0;
    end else if (Stall_ID) begin
      m_ex = bubble_instr();
      if (m_cnt < CNT_MAX) m_cnt++;
    end else begin
      m_ex.rs = Rs_val_ID; m_ex.rt = Rt_val_ID; m_ex.imm = imm_ID; m_ex.rw = Rw_ID;
      m_ex.src = ALU_SRC_ID; m_ex.we = we_ID; m_ex.ld = LD_ID; m_ex.mwe = mem_we_ID;
      m_ex.alu = alu_ctrl_ID; m_ex.sa = OP_A_SEL; m_ex.sb = OP_B_SEL;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt,
                        input logic [DATA_W-1:0] imm, input logic [REG_W-1:0] rw,
                        input logic src, input logic [3:0] alu, input logic we,
                        input logic ld, input logic mwe, input logic [1:0] sa,
                        input logic [1:0] sb);
    Rs_val_ID = rs; Rt_val_ID = rt; imm_ID = imm; Rw_ID = rw; ALU_SRC_ID = src;
    alu_ctrl_ID = alu; we_ID = we; LD_ID = ld; mem_we_ID = mwe;
    OP_A_SEL = sa; OP_B_SEL = sb;
  endtask

  task automatic ctrl(input logic h, input logic f, input logic s);
    hold_pipe = h; flush_ID = f; Stall_ID = s;
  endtask

  task automatic do_reset();
    reset = 1'b1; model_reset(); #2; reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; model_reset(); #1;
    n_cmp++;
    if ({we_ID_EX, LD_ID_EX, mem_we_EX, Rw_ID_EX, alu_ctrl_EX, op_a_EX, op_b_EX, store_data_EX, bubble_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_initial: outputs not zero, op_a=%h op_b=%h cnt=%0d", op_a_EX, op_b_EX, bubble_cnt);
    end
    reset = 1'b0;
    // Build up some non-zero state, then reset mid-cycle
    ctrl(0, 0, 1); tick();
    ctrl(0, 0, 0); set_in(32'h1234, 32'h5678, 32'h9, 5'd7, 1'b1, 4'd3, 1, 1, 1, 2'd0, 2'd0); tick();
    #2; reset = 1'b1; model_reset(); #1;
    n_cmp++;
    if ({we_ID_EX, LD_ID_EX, mem_we_EX, Rw_ID_EX, alu_ctrl_EX, op_a_EX, op_b_EX, store_data_EX} !== '0) begin
      n_bad++; $display("FAIL reset_midstream: outputs got op_a=%h op_b=%h we=%b rw=%0d required 0", op_a_EX, op_b_EX, we_ID_EX, Rw_ID_EX);
    end
    n_cmp++;
    if (bubble_cnt !== '0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d required 0", bubble_cnt);
    end
    $display("reset: mid-stream reset checked");
    reset = 1'b0; #1;
  endtask

  task automatic test_load();
    ctrl(0, 0, 0); set_in(32'd5, 32'd7, 32'd99, 5'd4, 1'b0, 4'd2, 1, 0, 0, 2'd0, 2'd0); tick();
    n_cmp++;
    if ({op_a_EX, op_b_EX, store_data_EX} !== {32'd5, 32'd7, 32'd7}) begin
      n_bad++; $display("FAIL load_ops: got a=%0d b=%0d sd=%0d required 5 7 7", op_a_EX, op_b_EX, store_data_EX);
    end
    n_cmp++;
    if ({Rw_ID_EX, we_ID_EX, alu_ctrl_EX} !== {5'd4, 1'b1, 4'd2}) begin
      n_bad++; $display("FAIL load_ctrl: got rw=%0d we=%b alu=%0d required 4 1 2", Rw_ID_EX, we_ID_EX, alu_ctrl_EX);
    end
    $display("load: rs=5 rt=7 -> a=%0d b=%0d sd=%0d", op_a_EX, op_b_EX, store_data_EX);
  endtask

  task automatic test_forward();
    ex_mem_result = 32'hAA; mem_wb_data = 32'hBB;
    set_in(32'd1, 32'd2, 32'h10, 5'd9, 1'b0, 4'd1, 1, 0, 0, 2'd1, 2'd2); tick();
    n_cmp++;
    if ({op_a_EX, op_b_EX, store_data_EX} !== {32'hAA, 32'hBB, 32'hBB}) begin
      n_bad++; $display("FAIL fwd_reg: got a=%h b=%h sd=%h required aa bb bb", op_a_EX, op_b_EX, store_data_EX);
    end
    set_in(32'd1, 32'd2, 32'h10, 5'd9, 1'b1, 4'd1, 1, 0, 1, 2'd1, 2'd2); tick();
    n_cmp++;
    if ({op_a_EX, op_b_EX, store_data_EX} !== {32'hAA, 32'h10, 32'hBB}) begin
      n_bad++; $display("FAIL fwd_imm: got a=%h b=%h sd=%h required aa 10 bb", op_a_EX, op_b_EX, store_data_EX);
    end
    // Select 11 falls back to the captured register values
    set_in(32'd3, 32'd4, 32'h10, 5'd9, 1'b0, 4'd1, 1, 0, 0, 2'd3, 2'd3); tick();
    n_cmp++;
    if ({op_a_EX, op_b_EX} !== {32'd3, 32'd4}) begin
      n_bad++; $display("FAIL fwd_sel11: got a=%h b=%h required 3 4", op_a_EX, op_b_EX);
    end
    $display("forward: sel 01/10/11 checked");
  endtask

  task automatic test_stall();
    do_reset();
    set_in(32'd8, 32'd9, 32'd0, 5'd6, 1'b0, 4'd5, 1, 1, 0, 2'd0, 2'd0);
    ctrl(0, 0, 1); tick(); tick();
    n_cmp++;
    if ({we_ID_EX, LD_ID_EX, Rw_ID_EX, op_a_EX} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      n_bad++; $display("FAIL stall_bubble: got we=%b ld=%b rw=%0d a=%h required 0 0 0 0", we_ID_EX, LD_ID_EX, Rw_ID_EX, op_a_EX);
    end
    n_cmp++;
    if (bubble_cnt !== 16'd2) begin
      n_bad++; $display("FAIL stall_cnt: got %0d required 2", bubble_cnt);
    end
    ctrl(0, 0, 0);
    $display("stall: two bubbles, cnt=%0d", bubble_cnt);
  endtask

  task automatic test_hold_flush();
    do_reset();
    ctrl(0, 0, 1); tick();                              // cnt = 1
    ctrl(0, 0, 0); set_in(32'h11, 32'h22, 32'h0, 5'd3, 1'b0, 4'd4, 1, 0, 0, 2'd0, 2'd0); tick();
    ctrl(1, 1, 0); set_in(32'h33, 32'h44, 32'h0, 5'd8, 1'b0, 4'd6, 1, 1, 1, 2'd0, 2'd0); tick();
    ctrl(1, 0, 1); tick(); tick();
    n_cmp++;
    if ({op_a_EX, op_b_EX, Rw_ID_EX, we_ID_EX, LD_ID_EX, alu_ctrl_EX, bubble_cnt} !==
        {32'h11, 32'h22, 5'd3, 1'b1, 1'b0, 4'd4, 16'd1}) begin
      n_bad++; $display("FAIL hold_frozen: got a=%h b=%h rw=%0d cnt=%0d required 11 22 3 1", op_a_EX, op_b_EX, Rw_ID_EX, bubble_cnt);
    end
    ctrl(0, 0, 0); tick();
    n_cmp++;
    if ({we_ID_EX, LD_ID_EX, mem_we_EX, Rw_ID_EX, op_a_EX, bubble_cnt} !== {1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 16'd1}) begin
      n_bad++; $display("FAIL hold_pending_flush: got we=%b rw=%0d a=%h cnt=%0d required 0 0 0 1", we_ID_EX, Rw_ID_EX, op_a_EX, bubble_cnt);
    end
    tick();
    n_cmp++;
    if ({op_a_EX, Rw_ID_EX} !== {32'h33, 5'd8}) begin
      n_bad++; $display("FAIL flush_pend_clear: got a=%h rw=%0d required 33 8", op_a_EX, Rw_ID_EX);
    end
    $display("hold: flush during hold applied after release");
  endtask

  task automatic test_flush_stall();
    set_in(32'h55, 32'h66, 32'h0, 5'd2, 1'b0, 4'd1, 1, 1, 0, 2'd0, 2'd0);
    ctrl(0, 1, 1); tick();
    n_cmp++;
    if ({we_ID_EX, LD_ID_EX, op_a_EX, bubble_cnt} !== {1'b0, 1'b0, 32'd0, 16'd1}) begin
      n_bad++; $display("FAIL flush_stall: got we=%b a=%h cnt=%0d required 0 0 1", we_ID_EX, op_a_EX, bubble_cnt);
    end
    ctrl(0, 0, 0);
    $display("flush+stall: bubble, cnt=%0d", bubble_cnt);
  endtask

  task automatic test_random();
    logic [123:0] got, exp;
    logic [DATA_W-1:0] fb;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
      ctrl($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
      tick();
      ex_mem_result = $urandom; mem_wb_data = $urandom; #1;
      fb  = fwd(m_ex.sb, m_ex.rt);
      exp = {m_ex.rw, m_ex.we, m_ex.ld, m_ex.mwe, m_ex.alu, fwd(m_ex.sa, m_ex.rs),
             m_ex.src ? m_ex.imm : fb, fb, CNT_W'(m_cnt)};
      got = {Rw_ID_EX, we_ID_EX, LD_ID_EX, mem_we_EX, alu_ctrl_EX, op_a_EX, op_b_EX, store_data_EX, bubble_cnt};
      n_cmp++;
      if (got !== exp) begin
        n_bad++; $display("FAIL random_%0d: got %h required %h", i, got, exp);
      end else
        $display("random %0d: h=%b f=%b s=%b a=%h b=%h cnt=%0d", i, hold_pipe, flush_ID, Stall_ID, op_a_EX, op_b_EX, bubble_cnt);
    end
    ctrl(0, 0, 0);
  endtask

  task automatic test_saturation();
    do_reset();
    ctrl(0, 0, 1);
    for (int i = 0; i < CNT_MAX; i++) tick();
    n_cmp++;
    if (bubble_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_reach: got %h required ffff", bubble_cnt);
    end
    tick(); tick();
    n_cmp++;
    if (bubble_cnt !== 16'hFFFF) begin
      n_bad++; $display("FAIL sat_hold: got %h required ffff", bubble_cnt);
    end
    ctrl(0, 0, 0);
    $display("saturation: cnt=%h after extra stalls", bubble_cnt);
  endtask

  initial begin
    model_reset();
    #2;
    test_reset();
    test_load();
    test_forward();
    test_stall();
    test_hold_flush();
    test_flush_stall();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
